bbox_overlay_tracker: RTL and testbench

Multi-object successor to the single hard-wired bounding-box overlay in the camera display path. It accepts per-object bounding-box results from the colour-detection stage (already synchronised into the display clock domain) through a valid/ready handshake. Updates are double-buffered so they apply only at frame start, positions are smoothed exponentially, and a box is hidden after a run of missed frames. It draws NUM_BOX coloured rectangle outlines of configurable thickness over the grayscale camera pixel stream before the VGA-to-HDMI encoder.

---
 rtl/bbox_overlay_tracker.sv | 276 +++++++++++++++++++++++++++
 tb/tb_bbox_overlay_tracker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_overlay_tracker.sv
`default_nettype none
// ============================================================================
// Module   : bbox_overlay_tracker
// Purpose  : Multi-object bounding-box overlay for the camera display path.
//            Accepts per-object box results through a valid/ready handshake,
//            stages them in pending slots, and commits them to display
//            registers at frame start. Positions are smoothed exponentially.
//            A box is hidden after a run of missed frames. Coloured outline
//            rectangles are drawn over the grayscale pixel stream with a
//            2-cycle latency.
// Ports    : clk, reset (async, active-high)
//            box_valid/box_ready/box_id/box_empty/box_{min,max}_{x,y}
//                                              - result handshake
//            frame_start                       - frame commit pulse
//            draw_x/draw_y/vde_in/pix_in       - raster input
//            red_out/green_out/blue_out/vde_out - composited output
//            box_active                        - per-box displayed flags
// Revision : 1.0 - initial multi-object release
// ============================================================================
module bbox_overlay_tracker #(
   parameter int NUM_BOX        = 2,
   parameter int ID_W           = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1,
   parameter int COORD_W        = 10,
   parameter int PIX_W          = 7,
   parameter int THICK          = 1,
   parameter int SMOOTH_SH      = 2,
   parameter int TIMEOUT_FRAMES = 15,
   parameter int H_ACT          = 640,
   parameter int V_ACT          = 480
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               box_valid,
   output logic               box_ready,
   input  logic [ID_W-1:0]    box_id,
   input  logic               box_empty,
   input  logic [COORD_W-1:0] box_min_x,
   input  logic [COORD_W-1:0] box_max_x,
   input  logic [COORD_W-1:0] box_min_y,
   input  logic [COORD_W-1:0] box_max_y,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] draw_x,
   input  logic [COORD_W-1:0] draw_y,
   input  logic               vde_in,
   input  logic [PIX_W-1:0]   pix_in,
   output logic [PIX_W-1:0]   red_out,
   output logic [PIX_W-1:0]   green_out,
   output logic [PIX_W-1:0]   blue_out,
   output logic               vde_out,
   output logic [NUM_BOX-1:0] box_active
);

   localparam int CW1 = COORD_W + 1;
   localparam int CW2 = COORD_W + 2;
   localparam logic [7:0]            C_TIMEOUT = 8'(TIMEOUT_FRAMES);
   localparam logic signed [CW2-1:0] C_XMAX    = CW2'(H_ACT - 1);
   localparam logic signed [CW2-1:0] C_YMAX    = CW2'(V_ACT - 1);
   localparam logic [CW1-1:0]        C_THICK   = CW1'(THICK);

   // Pending (next-frame) and display (current-frame) box state
   logic [NUM_BOX-1:0] r_pend_full;
   logic [NUM_BOX-1:0] r_pend_ok;      // 0 = stored as a miss
   logic [COORD_W-1:0] r_pend_min_x [NUM_BOX];
   logic [COORD_W-1:0] r_pend_max_x [NUM_BOX];
   logic [COORD_W-1:0] r_pend_min_y [NUM_BOX];
   logic [COORD_W-1:0] r_pend_max_y [NUM_BOX];
   logic [COORD_W-1:0] r_disp_min_x [NUM_BOX];
   logic [COORD_W-1:0] r_disp_max_x [NUM_BOX];
   logic [COORD_W-1:0] r_disp_min_y [NUM_BOX];
   logic [COORD_W-1:0] r_disp_max_y [NUM_BOX];
   logic [7:0]         r_miss_cnt   [NUM_BOX];
   logic [NUM_BOX-1:0] r_active;

   // ------------------------------------------------------------------
   // Handshake. Out-of-range ids match no slot, so they always see
   // ready=1 and their transfer lands nowhere.
   // ------------------------------------------------------------------
   logic               w_sel_full;
   logic [NUM_BOX-1:0] w_accept;
   logic               w_coords_ok;
   logic               w_pend_ok_in;

   always_comb begin
      w_sel_full = 1'b0;
      for (int i = 0; i < NUM_BOX; i++) begin
         if (box_id == ID_W'(i)) begin
            w_sel_full = r_pend_full[i];
         end
      end
   end

   assign box_ready = !w_sel_full;

   always_comb begin
      w_accept = '0;
      for (int i = 0; i < NUM_BOX; i++) begin
         w_accept[i] = box_valid && box_ready && (box_id == ID_W'(i));
      end
   end

   // A malformed or off-screen box is stored as if the object were not found
   assign w_coords_ok  = (box_min_x <= box_max_x) && (box_min_y <= box_max_y) &&
                         ({1'b0, box_max_x} < CW1'(H_ACT)) &&
                         ({1'b0, box_max_y} < CW1'(V_ACT));
   assign w_pend_ok_in = !box_empty && w_coords_ok;

   // disp + floor((new - disp) / 2^SMOOTH_SH), clamped to [0, lim].
   // Two guard bits keep the intermediate sum free of overflow.
   function automatic logic [COORD_W-1:0] f_smooth(
      input logic [COORD_W-1:0]    disp,
      input logic [COORD_W-1:0]    nxt,
      input logic signed [CW2-1:0] lim
   );
      logic signed [CW2-1:0] diff;
      logic signed [CW2-1:0] sum;
      diff = $signed({2'b00, nxt}) - $signed({2'b00, disp});
      sum  = $signed({2'b00, disp}) + (diff >>> SMOOTH_SH);
      if (sum[CW2-1])
         f_smooth = '0;
      else if (sum > lim)
         f_smooth = lim[COORD_W-1:0];
      else
         f_smooth = sum[COORD_W-1:0];
   endfunction

   // ------------------------------------------------------------------
   // Pending capture and frame-start commit. The commit reads the
   // pre-existing pending slot; a transfer accepted in the same cycle is
   // held for the following frame.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_full <= '0;
         r_pend_ok   <= '0;
         r_active    <= '0;
         for (int i = 0; i < NUM_BOX; i++) begin
            r_pend_min_x[i] <= '0;
            r_pend_max_x[i] <= '0;
            r_pend_min_y[i] <= '0;
            r_pend_max_y[i] <= '0;
            r_disp_min_x[i] <= '0;
            r_disp_max_x[i] <= '0;
            r_disp_min_y[i] <= '0;
            r_disp_max_y[i] <= '0;
            r_miss_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BOX; i++) begin
            if (w_accept[i]) begin
               r_pend_full[i]  <= 1'b1;
               r_pend_ok[i]    <= w_pend_ok_in;
               r_pend_min_x[i] <= box_min_x;
               r_pend_max_x[i] <= box_max_x;
               r_pend_min_y[i] <= box_min_y;
               r_pend_max_y[i] <= box_max_y;
            end else if (frame_start) begin
               r_pend_full[i]  <= 1'b0;
            end

            if (frame_start) begin
               if (r_pend_full[i] && r_pend_ok[i]) begin
                  if (r_active[i]) begin
                     r_disp_min_x[i] <= f_smooth(r_disp_min_x[i], r_pend_min_x[i], C_XMAX);
                     r_disp_max_x[i] <= f_smooth(r_disp_max_x[i], r_pend_max_x[i], C_XMAX);
                     r_disp_min_y[i] <= f_smooth(r_disp_min_y[i], r_pend_min_y[i], C_YMAX);
                     r_disp_max_y[i] <= f_smooth(r_disp_max_y[i], r_pend_max_y[i], C_YMAX);
                  end else begin
                     r_disp_min_x[i] <= r_pend_min_x[i];
                     r_disp_max_x[i] <= r_pend_max_x[i];
                     r_disp_min_y[i] <= r_pend_min_y[i];
                     r_disp_max_y[i] <= r_pend_max_y[i];
                  end
                  r_miss_cnt[i] <= '0;
                  r_active[i]   <= 1'b1;
               end else begin
                  if (r_miss_cnt[i] != C_TIMEOUT)
                     r_miss_cnt[i] <= r_miss_cnt[i] + 8'd1;
                  // Hide once the saturated count reaches the timeout
                  if (({1'b0, r_miss_cnt[i]} + 9'd1) >= {1'b0, C_TIMEOUT})
                     r_active[i] <= 1'b0;
               end
            end
         end
      end
   end

   assign box_active = r_active;

   // ------------------------------------------------------------------
   // Overlay stage 1: per-box outline hit test in COORD_W+1 bits so the
   // +THICK terms never wrap.
   // ------------------------------------------------------------------
   logic [NUM_BOX-1:0] w_hit;
   logic [CW1-1:0]     w_x;
   logic [CW1-1:0]     w_y;

   assign w_x = {1'b0, draw_x};
   assign w_y = {1'b0, draw_y};

   for (genvar gi = 0; gi < NUM_BOX; gi++) begin : g_box
      logic [CW1-1:0] w_mnx, w_mxx, w_mny, w_mxy;
      assign w_mnx = {1'b0, r_disp_min_x[gi]};
      assign w_mxx = {1'b0, r_disp_max_x[gi]};
      assign w_mny = {1'b0, r_disp_min_y[gi]};
      assign w_mxy = {1'b0, r_disp_max_y[gi]};
      assign w_hit[gi] = r_active[gi] &&
                         (w_x >= w_mnx) && (w_x <= w_mxx) &&
                         (w_y >= w_mny) && (w_y <= w_mxy) &&
                         ((w_y < w_mny + C_THICK) || (w_y + C_THICK > w_mxy) ||
                          (w_x < w_mnx + C_THICK) || (w_x + C_THICK > w_mxx));
   end

   logic [NUM_BOX-1:0] r_s1_hit;
   logic               r_s1_vde;
   logic [PIX_W-1:0]   r_s1_pix;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_hit <= '0;
         r_s1_vde <= 1'b0;
         r_s1_pix <= '0;
      end else begin
         r_s1_hit <= w_hit;
         r_s1_vde <= vde_in;
         r_s1_pix <= pix_in;
      end
   end

   // ------------------------------------------------------------------
   // Overlay stage 2: lowest-index hit wins; scanning downward lets the
   // lowest index overwrite any higher one.
   // ------------------------------------------------------------------
   logic [PIX_W-1:0] w_r, w_g, w_b;

   always_comb begin
      w_r = r_s1_pix;
      w_g = r_s1_pix;
      w_b = r_s1_pix;
      for (int i = NUM_BOX - 1; i >= 0; i--) begin
         if (r_s1_hit[i]) begin
            w_r = ((i % 3) == 0) ? '1 : '0;
            w_g = ((i % 3) == 1) ? '1 : '0;
            w_b = ((i % 3) == 2) ? '1 : '0;
         end
      end
      if (!r_s1_vde) begin
         w_r = '0;
         w_g = '0;
         w_b = '0;
      end
   end

   logic [PIX_W-1:0] r_red, r_green, r_blue;
   logic             r_vde;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_vde   <= 1'b0;
      end else begin
         r_red   <= w_r;
         r_green <= w_g;
         r_blue  <= w_b;
         r_vde   <= r_s1_vde;
      end
   end

   assign red_out   = r_red;
   assign green_out = r_green;
   assign blue_out  = r_blue;
   assign vde_out   = r_vde;

endmodule
`default_nettype wire

// File: tb/tb_bbox_overlay_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbox_overlay_tracker
// Purpose  : Self-checking bench for bbox_overlay_tracker. A behavioural
//            model of pending/display/miss state and of the outline drawing
//            rules predicts every output; a negedge process compares the DUT
//            against it each cycle, and directed scenarios add literal checks.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_bbox_overlay_tracker;

   localparam int NUM_BOX = 2;
   localparam int ID_W    = 1;
   localparam int COORD_W = 10;
   localparam int PIX_W   = 7;
   localparam int THICK   = 1;
   localparam int SH      = 2;
   localparam int TO      = 15;
   localparam int H       = 640;
   localparam int V       = 480;

   logic               clk = 1'b0;
   logic               reset;
   logic               box_valid;
   logic               box_ready;
   logic [ID_W-1:0]    box_id;
   logic               box_empty;
   logic [COORD_W-1:0] box_min_x, box_max_x, box_min_y, box_max_y;
   logic               frame_start;
   logic [COORD_W-1:0] draw_x, draw_y;
   logic               vde_in;
   logic [PIX_W-1:0]   pix_in;
   logic [PIX_W-1:0]   red_out, green_out, blue_out;
   logic               vde_out;
   logic [NUM_BOX-1:0] box_active;

   bbox_overlay_tracker #(
      .NUM_BOX(NUM_BOX), .ID_W(ID_W), .COORD_W(COORD_W), .PIX_W(PIX_W),
      .THICK(THICK), .SMOOTH_SH(SH), .TIMEOUT_FRAMES(TO), .H_ACT(H), .V_ACT(V)
   ) dut (
      .clk(clk), .reset(reset),
      .box_valid(box_valid), .box_ready(box_ready), .box_id(box_id),
      .box_empty(box_empty),
      .box_min_x(box_min_x), .box_max_x(box_max_x),
      .box_min_y(box_min_y), .box_max_y(box_max_y),
      .frame_start(frame_start), .draw_x(draw_x), .draw_y(draw_y),
      .vde_in(vde_in), .pix_in(pix_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .vde_out(vde_out), .box_active(box_active)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_pfull [NUM_BOX];
   int m_pok   [NUM_BOX];
   int m_pc    [NUM_BOX][4];   // min_x, max_x, min_y, max_y
   int m_dc    [NUM_BOX][4];
   int m_act   [NUM_BOX];
   int m_miss  [NUM_BOX];
   int drv_id = 0;

   typedef struct { int r; int g; int b; int vde; } exp_t;
   exp_t e1, e2;

   task automatic model_clear();
      for (int i = 0; i < NUM_BOX; i++) begin
         m_pfull[i] = 0; m_pok[i] = 0; m_act[i] = 0; m_miss[i] = 0;
         for (int k = 0; k < 4; k++) begin m_pc[i][k] = 0; m_dc[i][k] = 0; end
      end
      e1 = '{0, 0, 0, 0};
      e2 = '{0, 0, 0, 0};
   endtask

   function automatic int floor_div(int n, int d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   function automatic int smooth(int d, int n, int lim);
      int r;
      r = d + floor_div(n - d, 1 << SH);
      if (r < 0) r = 0;
      if (r > lim) r = lim;
      return r;
   endfunction

   function automatic exp_t model_pix(int vde, int x, int y, int pix);
      exp_t e;
      e = '{0, 0, 0, 0};
      if (vde == 0) return e;
      e = '{pix, pix, pix, 1};
      for (int i = 0; i < NUM_BOX; i++) begin
         if (m_act[i] != 0 && x >= m_dc[i][0] && x <= m_dc[i][1] &&
             y >= m_dc[i][2] && y <= m_dc[i][3] &&
             (x - m_dc[i][0] < THICK || m_dc[i][1] - x < THICK ||
              y - m_dc[i][2] < THICK || m_dc[i][3] - y < THICK)) begin
            e.r = (i % 3 == 0) ? 127 : 0;
            e.g = (i % 3 == 1) ? 127 : 0;
            e.b = (i % 3 == 2) ? 127 : 0;
            return e;
         end
      end
      return e;
   endfunction

   task automatic model_commit();
      for (int i = 0; i < NUM_BOX; i++) begin
         if (m_pfull[i] != 0 && m_pok[i] != 0) begin
            if (m_act[i] != 0) begin
               for (int k = 0; k < 4; k++)
                  m_dc[i][k] = smooth(m_dc[i][k], m_pc[i][k], (k < 2) ? H - 1 : V - 1);
            end else begin
               for (int k = 0; k < 4; k++) m_dc[i][k] = m_pc[i][k];
            end
            m_miss[i] = 0;
            m_act[i]  = 1;
         end else begin
            if (m_miss[i] < TO) m_miss[i]++;
            if (m_miss[i] == TO) m_act[i] = 0;
         end
         m_pfull[i] = 0;
      end
   endtask

   function automatic int model_active_vec();
      int v = 0;
      for (int i = 0; i < NUM_BOX; i++) if (m_act[i] != 0) v |= (1 << i);
      return v;
   endfunction

   function automatic int model_ready();
      if (drv_id < NUM_BOX) return (m_pfull[drv_id] != 0) ? 0 : 1;
      return 1;
   endfunction

   // One clock of stimulus; the model advances right after the edge.
   task automatic step(input int fs, input int v, input int id, input int emp,
                       input int mnx, input int mxx, input int mny, input int mxy,
                       input int vde, input int x, input int y, input int pix);
      exp_t cur;
      int   acc, ok;
      frame_start = fs[0];
      box_valid   = v[0];
      box_id      = ID_W'(id);
      drv_id      = id;
      box_empty   = emp[0];
      box_min_x   = COORD_W'(mnx); box_max_x = COORD_W'(mxx);
      box_min_y   = COORD_W'(mny); box_max_y = COORD_W'(mxy);
      vde_in      = vde[0];
      draw_x      = COORD_W'(x);   draw_y = COORD_W'(y);
      pix_in      = PIX_W'(pix);
      cur = model_pix(vde, x, y, pix);
      acc = (v != 0 && model_ready() != 0 && id < NUM_BOX) ? 1 : 0;
      ok  = (emp == 0 && mnx <= mxx && mny <= mxy && mxx < H && mxy < V) ? 1 : 0;
      @(posedge clk);
      #1;
      if (fs != 0) model_commit();
      if (acc != 0) begin
         m_pfull[id] = 1;
         m_pok[id]   = ok;
         m_pc[id][0] = mnx; m_pc[id][1] = mxx; m_pc[id][2] = mny; m_pc[id][3] = mxy;
      end
      e2 = e1;
      e1 = cur;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic xfer(input int id, input int emp, input int a, input int b,
                       input int c, input int d);
      step(0, 1, id, emp, a, b, c, d, 0, 0, 0, 0);
   endtask

   task automatic fstart();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic probe(input string name, input int x, input int y, input int pix,
                        input int er, input int eg, input int eb);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, x, y, pix);
      idle();
      chk({name, "_r"}, red_out, er);
      chk({name, "_g"}, green_out, eg);
      chk({name, "_b"}, blue_out, eb);
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("cyc_red",    red_out,    e2.r);
      chk("cyc_green",  green_out,  e2.g);
      chk("cyc_blue",   blue_out,   e2.b);
      chk("cyc_vde",    vde_out,    e2.vde);
      chk("cyc_active", box_active, model_active_vec());
      chk("cyc_ready",  box_ready,  model_ready());
   end

   initial begin
      int fell;
      reset = 1'b1;
      frame_start = 0; box_valid = 0; box_id = '0; box_empty = 0;
      box_min_x = '0; box_max_x = '0; box_min_y = '0; box_max_y = '0;
      draw_x = '0; draw_y = '0; vde_in = 0; pix_in = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_active", box_active, 0);
      chk("rst_red",    red_out, 0);
      chk("rst_vde",    vde_out, 0);
      chk("rst_ready",  box_ready, 1);
      reset = 1'b0;

      // First detection loads directly
      xfer(0, 0, 100, 200, 50, 150);
      fstart();
      chk("t1_active", box_active, 1);
      probe("t1_edge", 100, 80, 40, 127, 0, 0);
      probe("t1_inner", 150, 100, 40, 40, 40, 40);

      // Pending slot full blocks a second transfer; smoothing on commit
      xfer(0, 0, 140, 200, 50, 150);
      chk("t2_ready_low", box_ready, 0);
      xfer(0, 0, 300, 400, 60, 70);
      fstart();
      chk("t2_model_minx", m_dc[0][0], 110);
      probe("t2_newedge", 110, 80, 33, 127, 0, 0);
      probe("t2_oldedge", 100, 80, 33, 33, 33, 33);

      // Overlap: id0 wins the shared pixel
      xfer(1, 0, 150, 250, 100, 200);
      fstart();
      probe("t4_shared", 200, 100, 20, 127, 0, 0);
      probe("t4_id1", 250, 180, 20, 0, 127, 0);

      // Malformed transfers count as misses
      xfer(1, 0, 300, 200, 100, 200);
      fstart();
      chk("t5_miss1", m_miss[1], 1);
      probe("t5_keep1", 250, 180, 20, 0, 127, 0);
      xfer(1, 0, 150, 250, 100, 480);
      fstart();
      chk("t5_miss2", m_miss[1], 2);
      probe("t5_keep2", 250, 180, 20, 0, 127, 0);

      // Timeout: id0 has missed 3 frames so far
      fell = 0;
      for (int k = 4; k <= 20; k++) begin
         if (fell == 0) begin
            fstart();
            if (box_active[0] == 1'b0) fell = k;
         end
      end
      chk("t3_timeout_frame", fell, 15);
      probe("t3_gray", 100, 80, 50, 50, 50, 50);
      probe("t3_gray2", 110, 80, 50, 50, 50, 50);

      // Transfer coincident with frame_start lands next frame
      step(1, 1, 0, 0, 300, 400, 300, 400, 0, 0, 0, 0);
      chk("t6_not_yet", box_active[0], 0);
      fstart();
      chk("t6_now", box_active[0], 1);
      probe("t6_edge", 300, 350, 9, 127, 0, 0);

      // Asynchronous reset mid-line
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 300, 350, 9);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 300, 351, 9);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 300, 352, 9);
      chk("t6_pre_reset_red", red_out, 127);
      reset = 1'b1;
      #1;
      chk("t6_rst_red",    red_out, 0);
      chk("t6_rst_vde",    vde_out, 0);
      chk("t6_rst_active", box_active, 0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
      probe("t6_after_rst", 300, 350, 9, 9, 9, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
